// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. Holds the fetch PC and issues one single-word read
//   per cycle to memory. Returned words are buffered with their PCs in a small
//   prefetch FIFO, and decode drains that FIFO through a valid/ready handshake.
//   A redirect flushes the FIFO, drops any in-flight read and restarts fetch at
//   the new PC.
//
//   Optional feature macro: FETCH_ALIGN_CHECK_EN
//     defined   : a misaligned redirect halts fetch and sets a sticky align_err.
//                 A later aligned redirect clears both.
//     undefined : the redirect target is force-aligned and align_err is tied 0.
//
// Ports
//   clock, reset_n            clock; asynchronous active-low reset
//   fetch_en                  1 = new reads may be issued
//   redirect, redirect_pc     flush and restart fetch at redirect_pc
//   mem_address/rw/enable/
//   mem_access_size/wdata     read request to memory (rw=1, size 2'b00, wdata 0)
//   mem_rdata                 read data, valid the cycle after the request
//   insn, insn_pc, insn_valid head of the prefetch FIFO
//   insn_ready                decode accepts the head
//   align_err                 sticky misaligned-redirect flag
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter int                ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] START_ADDR = 32'h8002_0000,
   parameter int                FIFO_DEPTH = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              fetch_en,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_rw,
   output logic              mem_enable,
   output logic [1:0]        mem_access_size,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic [31:0]       insn,
   output logic [ADDR_W-1:0] insn_pc,
   output logic              insn_valid,
   input  logic              insn_ready,
   output logic              align_err
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic              inflight_q, inflight_d;
   logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
   logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [31:0]       fifo_insn_q [FIFO_DEPTH];
   logic [ADDR_W-1:0] fifo_pc_q   [FIFO_DEPTH];

   logic halted;
   logic credit_ok;
   logic push, pop;

`ifdef FETCH_ALIGN_CHECK_EN
   logic halted_q, halted_d;
   logic align_err_q, align_err_d;
   assign halted    = halted_q;
   assign align_err = align_err_q;
`else
   // Low address bits are discarded when the target is force-aligned.
   logic unused_redirect_lsbs;
   assign unused_redirect_lsbs = ^redirect_pc[1:0];
   assign halted    = 1'b0;
   assign align_err = 1'b0;
`endif

   // A read is issued only if the FIFO has room for it, counting the word that
   // is already in flight. This makes it impossible to push into a full FIFO.
   assign credit_ok  = ({1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q}) < (CNT_W + 1)'(FIFO_DEPTH);
   assign mem_enable = reset_n & fetch_en & ~redirect & ~halted & credit_ok;

   assign mem_address     = fetch_pc_q;
   assign mem_rw          = 1'b1;
   assign mem_access_size = 2'b00;
   assign mem_wdata       = 32'h0;

   assign insn_valid = (count_q != '0);
   assign push       = inflight_q & ~redirect;
   assign pop        = insn_valid & insn_ready & ~redirect;

   // The output is forced to zero while empty, so it reads 0 during reset even
   // though the storage itself is not reset.
   assign insn    = insn_valid ? fifo_insn_q[head_q] : 32'h0;
   assign insn_pc = insn_valid ? fifo_pc_q[head_q]   : '0;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      fetch_pc_d    = fetch_pc_q;
      inflight_d    = mem_enable;
      inflight_pc_d = inflight_pc_q;
      head_d        = head_q;
      tail_d        = tail_q;
      count_d       = count_q;
`ifdef FETCH_ALIGN_CHECK_EN
      halted_d      = halted_q;
      align_err_d   = align_err_q;
`endif

      if (mem_enable) begin
         inflight_pc_d = fetch_pc_q;
         fetch_pc_d    = fetch_pc_q + ADDR_W'(4);
      end
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // A redirect overrides everything else. No read is issued in the redirect
      // cycle, so fetch_pc_q is still the pre-redirect value here.
      if (redirect) begin
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
         inflight_d = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
         if (redirect_pc[1:0] != 2'b00) begin
            halted_d    = 1'b1;
            align_err_d = 1'b1;
         end else begin
            halted_d    = 1'b0;
            align_err_d = 1'b0;
            fetch_pc_d  = redirect_pc;
         end
`else
         fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
`endif
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fetch_pc_q    <= START_ADDR;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
         halted_q      <= 1'b0;
         align_err_q   <= 1'b0;
`endif
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples its pre-edge value, independent of statement order.
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
`ifdef FETCH_ALIGN_CHECK_EN
         halted_q      <= halted_d;
         align_err_q   <= align_err_d;
`endif
      end
   end

   // NOTE: the FIFO storage has no reset. Its contents are only visible when
   // count_q says they are valid, so resetting them would gain nothing.
   always_ff @(posedge clock) begin
      if (push) begin
         fifo_insn_q[tail_q] <= mem_rdata;
         fifo_pc_q[tail_q]   <= inflight_pc_q;
      end
   end

   a_no_push_when_full: assert property (@(posedge clock) disable iff (!reset_n)
      !(push && (count_q == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Random and directed stimulus for fetch_unit, with a behavioural memory.
//   The reference model is the rule "after a reset or redirect to P, decode
//   sees P, P+4, P+8, ... each paired with mem[pc]". The driver keeps a queue
//   of those expected words filled. A separate monitor pops one entry for each
//   accepted handshake and compares it with the DUT output.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

   localparam logic [31:0] START = 32'h8002_0000;
   localparam int          DEPTH = 4;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        fetch_en = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic [31:0] mem_address;
   logic        mem_rw;
   logic        mem_enable;
   logic [1:0]  mem_access_size;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = 32'h0;
   logic [31:0] insn;
   logic [31:0] insn_pc;
   logic        insn_valid;
   logic        insn_ready = 1'b0;
   logic        align_err;

   fetch_unit #(.ADDR_W(32), .START_ADDR(START), .FIFO_DEPTH(DEPTH)) dut (
      .clock(clock), .reset_n(reset_n), .fetch_en(fetch_en),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .mem_address(mem_address), .mem_rw(mem_rw), .mem_enable(mem_enable),
      .mem_access_size(mem_access_size), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .insn(insn), .insn_pc(insn_pc),
      .insn_valid(insn_valid), .insn_ready(insn_ready), .align_err(align_err)
   );

   always #5 clock = ~clock;

   // Memory contents: the first four words are fixed, every other word is a
   // function of its address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h8002_0000: return 32'h1111_1111;
         32'h8002_0004: return 32'h2222_2222;
         32'h8002_0008: return 32'h3333_3333;
         32'h8002_000C: return 32'h4444_4444;
         default:       return (a ^ 32'hC3A5_5A3C) + 32'h0101_0101;
      endcase
   endfunction

   // Synchronous-read memory: data is valid the cycle after the request.
   always @(posedge clock) if (mem_enable) mem_rdata <= mem_word(mem_address);

   // ---------------- scoreboard / reference model ----------------
   typedef struct packed { logic [31:0] pc; logic [31:0] word; } exp_t;
   exp_t        exp_q[$];
   logic [31:0] model_next_pc = START;
   bit          model_halted = 1'b0;
   bit          model_align  = 1'b0;
   int          n_cmp  = 0;
   int          n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      model_next_pc = START;
      model_halted  = 1'b0;
      model_align   = 1'b0;
   endtask

   task automatic model_redirect(input logic [31:0] pc);
      exp_q.delete();
`ifdef FETCH_ALIGN_CHECK_EN
      if (pc[1:0] != 2'b00) begin
         model_halted = 1'b1;
         model_align  = 1'b1;
      end else begin
         model_halted  = 1'b0;
         model_align   = 1'b0;
         model_next_pc = pc;
      end
`else
      model_next_pc = {pc[31:2], 2'b00};
`endif
   endtask

   task automatic refill();
      exp_t e;
      while (!model_halted && exp_q.size() < 8) begin
         e.pc   = model_next_pc;
         e.word = mem_word(model_next_pc);
         exp_q.push_back(e);
         model_next_pc = model_next_pc + 32'd4;
      end
   endtask

   // Drive one cycle of inputs at the falling edge and update the model.
   task automatic step(input bit rst_v, input bit fen, input bit rdy,
                       input bit rd, input logic [31:0] rpc);
      @(negedge clock);
      reset_n     = rst_v;
      fetch_en    = fen;
      insn_ready  = rdy;
      redirect    = rd;
      redirect_pc = rpc;
      if (!rst_v)  model_reset();
      else if (rd) model_redirect(rpc);
      refill();
   endtask

   // ---------------- monitor ----------------
   exp_t mon_e;
   always @(negedge clock) begin
      #1;
      if (!reset_n) begin
         check("rst_insn_valid", insn_valid, 0);
         check("rst_insn",       insn,       0);
         check("rst_insn_pc",    insn_pc,    0);
         check("rst_mem_enable", mem_enable, 0);
         check("rst_align_err",  align_err,  0);
      end else begin
         if (insn_valid && insn_ready && !redirect) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL sb_underflow: got pc %h with no expected entry", insn_pc);
            end else begin
               mon_e = exp_q.pop_front();
               check("insn_pc", insn_pc, mon_e.pc);
               check("insn",    insn,    mon_e.word);
            end
         end
         if (!redirect) begin
            check("align_err", align_err, model_align);
            if (model_halted) check("halted_mem_enable", mem_enable, 0);
         end
         check("mem_ctrl", {29'h0, mem_rw, mem_access_size}, 32'h4);
         check("mem_wdata", mem_wdata, 0);
      end
   end

   // ---------------- directed + random stimulus ----------------
   initial begin
      int first;
      int issues;
      bit fen, rdy, rd;
      logic [31:0] rpc;

      // Phase A: reset release, streaming, first-valid latency.
      repeat (3) step(0, 0, 0, 0, 0);
      first = -1;
      for (int k = 0; k < 10; k++) begin
         step(1, 1, 1, 0, 0);
         #2;
         if (k == 0) check("first_addr", mem_address, START);
         if (first < 0 && insn_valid) first = k;
      end
      check("first_valid_cycle", first, 2);

      // Phase B: stall decode, FIFO fills with exactly DEPTH words.
      repeat (2) step(0, 0, 0, 0, 0);
      issues = 0;
      for (int k = 0; k < 10; k++) begin
         step(1, 1, 0, 0, 0);
         #2;
         if (mem_enable) issues++;
      end
      check("fill_issue_count", issues, DEPTH);
      check("fill_mem_enable", mem_enable, 0);
      check("fill_insn_valid", insn_valid, 1);
      for (int k = 0; k < 12; k++) begin
         step(1, 1, 1, 0, 0);
         #2;
         check("stream_no_gap", insn_valid, 1);
      end

      // Phase C: redirect with 3 words buffered and one read in flight.
      repeat (2) step(0, 0, 0, 0, 0);
      repeat (4) step(1, 1, 0, 0, 0);
      step(1, 1, 1, 1, 32'h8002_0100);
      #2 check("pre_redirect_valid", insn_valid, 1);
      step(1, 1, 1, 0, 0);
      #2;
      check("redir_req_en",   mem_enable,  1);
      check("redir_req_addr", mem_address, 32'h8002_0100);
      check("redir_valid_r1", insn_valid,  0);
      step(1, 1, 1, 0, 0);
      #2 check("redir_valid_r2", insn_valid, 0);
      step(1, 1, 1, 0, 0);
      #2 check("redir_valid_r3", insn_valid, 1);
      repeat (4) step(1, 1, 1, 0, 0);

      // Phase D: PC wraps past the top of the address space.
      step(1, 1, 1, 1, 32'hFFFF_FFF8);
      repeat (8) step(1, 1, 1, 0, 0);

      // Phase E: misaligned redirect.
      step(1, 1, 1, 1, 32'h8002_0102);
`ifdef FETCH_ALIGN_CHECK_EN
      for (int k = 0; k < 5; k++) begin
         step(1, 1, 1, 0, 0);
         #2;
         check("misalign_err", align_err, 1);
         check("misalign_halt", mem_enable, 0);
      end
      step(1, 1, 1, 1, 32'h8002_0200);
      step(1, 1, 1, 0, 0);
      #2;
      check("realign_err", align_err, 0);
      check("realign_addr", mem_address, 32'h8002_0200);
`else
      step(1, 1, 1, 0, 0);
      #2;
      check("misalign_err", align_err, 0);
      check("misalign_addr", mem_address, 32'h8002_0100);
`endif
      repeat (6) step(1, 1, 1, 0, 0);

      // Phase F: reset pulse mid-stream, then restart from START.
      repeat (3) step(1, 1, 1, 0, 0);
      step(0, 1, 1, 0, 0);
      step(1, 1, 1, 0, 0);
      #2 check("restart_addr", mem_address, START);
      repeat (6) step(1, 1, 1, 0, 0);

      // Phase G: random traffic.
      for (int k = 0; k < 2000; k++) begin
         if ($urandom_range(0, 299) == 0) begin
            step(0, 1, 1, 0, 0);
         end else begin
            fen = ($urandom_range(0, 9) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 19) == 0);
            rpc = 32'h8002_0000 + ($urandom_range(0, 255) << 2);
            if ($urandom_range(0, 9) == 0) rpc = 32'hFFFF_FFF0;
            if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            step(1, fen, rdy, rd, rpc);
         end
      end
      step(1, 1, 1, 1, 32'h8002_0300);
      repeat (8) step(1, 1, 1, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
